// File: rtl/pwm_pkg.sv
// pwm_pkg: shared CTRL bit indices, counter state encoding and register offsets
package pwm_pkg;
  localparam int CTRL_EN = 0;
  localparam int CTRL_CENTER = 1;
  typedef enum logic {ST_UP, ST_DOWN} state_t;
  function automatic int top_addr(input int channels);
    return channels;
  endfunction
  function automatic int ctrl_addr(input int channels);
    return channels + 1;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: duty shadow/active pair with boundary forwarding and registered compare
module pwm_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);
  logic [WIDTH-1:0] duty_sh, duty_act;
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wr) duty_sh <= wr_data;
      if (load) duty_act <= wr ? wr_data : duty_sh;
      pwm <= run && (cnt < duty_act);
    end
  end
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: shared edge/center period counter driving double-buffered PWM channels
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [$clog2(CHANNELS+2)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]                wr_data,
  output logic [CHANNELS-1:0]             pwm_out,
  output logic [WIDTH-1:0]                cnt_out,
  output logic                            period_tick
);
  localparam int ADDR_W = $clog2(CHANNELS + 2);
  localparam logic [ADDR_W-1:0] A_TOP = ADDR_W'(top_addr(CHANNELS));
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(ctrl_addr(CHANNELS));
  state_t state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx, top_sh, top_act;
  logic en, en_nx, center_sh, center_act;
  logic wr_top, wr_ctrl, run, boundary, load;
  assign wr_top = wr_en && (wr_addr == A_TOP);
  assign wr_ctrl = wr_en && (wr_addr == A_CTRL);
  assign en_nx = wr_ctrl ? wr_data[CTRL_EN] : en;
  assign run = en && en_nx;
  assign boundary = (top_act == '0) ||
                    (center_act ? (state == ST_DOWN && cnt == '0) : (cnt == top_act));
  assign load = !en || boundary;
  assign period_tick = en && (cnt == '0) && (state == ST_UP || !center_act);
  assign cnt_out = cnt;
  always_comb begin
    cnt_nx   = '0;
    state_nx = ST_UP;
    if (run && top_act != '0) begin
      if (!center_act) begin
        cnt_nx = (cnt == top_act) ? '0 : cnt + WIDTH'(1);
      end else if (state == ST_UP) begin
        state_nx = (cnt == top_act - WIDTH'(1)) ? ST_DOWN : ST_UP;
        cnt_nx   = (cnt == top_act - WIDTH'(1)) ? cnt : cnt + WIDTH'(1);
      end else begin
        state_nx = (cnt == '0) ? ST_UP : ST_DOWN;
        cnt_nx   = (cnt == '0) ? cnt : cnt - WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      state      <= ST_UP;
      en         <= 1'b0;
      center_sh  <= 1'b0;
      center_act <= 1'b0;
      top_sh     <= '1;
      top_act    <= '1;
    end else begin
      cnt   <= cnt_nx;
      state <= state_nx;
      en    <= en_nx;
      if (wr_top) top_sh <= wr_data;
      if (wr_ctrl) center_sh <= wr_data[CTRL_CENTER];
      if (load) begin
        top_act    <= wr_top ? wr_data : top_sh;
        center_act <= wr_ctrl ? wr_data[CTRL_CENTER] : center_sh;
      end
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr_en && (wr_addr == ADDR_W'(i))),
      .load    (load),
      .run     (run),
      .wr_data (wr_data),
      .cnt     (cnt),
      .pwm     (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: randomized and directed stimulus checked against a period-phase reference model
module tb_pwm_multichannel;
  localparam int CH = 4;
  localparam int AW = $clog2(CH + 2);
  localparam int A_TOP = CH;
  localparam int A_CTRL = CH + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [CH-1:0] pwm_out;
  logic [7:0] cnt_out;
  logic period_tick;
  typedef struct {
    int cnt;
    logic [CH-1:0] pwm;
    logic tick;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_vec = 0;
  int n_bad = 0;
  int m_duty_sh[CH], m_duty_act[CH];
  int m_top_sh, m_top_act, m_p;
  bit m_cen_sh, m_cen_act, m_en;
  logic [CH-1:0] m_pwm;
  pwm_multichannel #(.WIDTH(8), .CHANNELS(CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .cnt_out     (cnt_out),
    .period_tick (period_tick)
  );
  always #5 clk = ~clk;
  function automatic int period_of();
    if (m_top_act == 0) return 1;
    return m_cen_act ? 2 * m_top_act : m_top_act + 1;
  endfunction
  function automatic int cnt_of();
    if (m_top_act == 0) return 0;
    if (!m_cen_act) return m_p;
    return (m_p < m_top_act) ? m_p : 2 * m_top_act - 1 - m_p;
  endfunction
  task automatic model_step(input bit r, input bit w, input int a, input int d);
    int c;
    bit bnd, ld, en_nx;
    exp_t x;
    if (r) begin
      foreach (m_duty_sh[i]) begin
        m_duty_sh[i] = 0;
        m_duty_act[i] = 0;
      end
      m_top_sh = 255;
      m_top_act = 255;
      m_cen_sh = 0;
      m_cen_act = 0;
      m_en = 0;
      m_p = 0;
      m_pwm = '0;
    end else begin
      c = cnt_of();
      bnd = (m_p == period_of() - 1);
      ld = !m_en || bnd;
      en_nx = (w && a == A_CTRL) ? bit'(d & 1) : m_en;
      for (int i = 0; i < CH; i++) m_pwm[i] = m_en && en_nx && (c < m_duty_act[i]);
      if (w && a < CH) m_duty_sh[a] = d;
      if (w && a == A_TOP) m_top_sh = d;
      if (w && a == A_CTRL) m_cen_sh = bit'((d >> 1) & 1);
      if (ld) begin
        foreach (m_duty_sh[i]) m_duty_act[i] = m_duty_sh[i];
        m_top_act = m_top_sh;
        m_cen_act = m_cen_sh;
      end
      m_p = (m_en && en_nx && !bnd) ? m_p + 1 : 0;
      m_en = en_nx;
    end
    x.cnt = cnt_of();
    x.pwm = m_pwm;
    x.tick = m_en && (m_p == 0);
    q.push_back(x);
  endtask
  task automatic cyc(input bit r, input bit w, input int a, input int d);
    @(negedge clk);
    rst = r;
    wr_en = w;
    wr_addr = AW'(a);
    wr_data = 8'(d);
    model_step(r, w, a, d);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
  endtask
  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (cnt_of() != v && k < 600) begin
      cyc(0, 0, 0, 0);
      k++;
    end
    if (k >= 600) begin
      $display("FAIL wait_cnt: model cnt %0d never reached required %0d", cnt_of(), v);
      n_bad++;
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (cnt_out !== 8'(e.cnt)) begin
        $display("FAIL cnt_out t=%0t got %0d expected %0d", $time, cnt_out, e.cnt);
        n_bad++;
      end
      if (pwm_out !== e.pwm) begin
        $display("FAIL pwm_out t=%0t got %b expected %b", $time, pwm_out, e.pwm);
        n_bad++;
      end
      if (period_tick !== e.tick) begin
        $display("FAIL period_tick t=%0t got %b expected %b", $time, period_tick, e.tick);
        n_bad++;
      end
    end
  end
  initial begin
    int a, d;
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0);
    cyc(0, 1, A_TOP, 9);
    cyc(0, 1, 0, 3);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 2, 10);
    cyc(0, 1, 3, 255);
    cyc(0, 1, A_CTRL, 1);
    idle(40);
    wait_cnt(4);
    cyc(0, 1, 0, 7);
    idle(25);
    cyc(0, 1, 0, 3);
    idle(15);
    wait_cnt(9);
    cyc(0, 1, 0, 7);
    idle(20);
    cyc(0, 1, A_TOP, 4);
    cyc(0, 1, 0, 2);
    cyc(0, 1, A_CTRL, 3);
    idle(40);
    cyc(0, 1, A_CTRL, 1);
    cyc(0, 1, A_TOP, 9);
    idle(25);
    wait_cnt(5);
    cyc(0, 1, A_CTRL, 0);
    idle(3);
    cyc(0, 1, 0, 6);
    cyc(0, 1, A_CTRL, 1);
    idle(25);
    wait_cnt(3);
    cyc(1, 1, A_TOP, 5);
    idle(3);
    cyc(0, 1, 0, 100);
    cyc(0, 1, A_CTRL, 1);
    idle(520);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) cyc(1, 0, 0, 0);
      else if ($urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, (1 << AW) - 1);
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
        if (a == A_CTRL) d = int'($urandom_range(0, 9) != 0) | ($urandom_range(0, 1) << 1);
        cyc(0, 1, a, d);
      end else cyc(0, 0, 0, 0);
    end
    idle(2);
    repeat (3) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, required 0", q.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator. One shared period counter drives CHANNELS compare outputs. It adds programmable period (TOP), edge- or center-aligned modes, and double-buffered duty/period/mode updates applied only at period boundaries. It sits between the pin-level wrapper and a simple register-write port, and exposes its counter for bring-up and test.

## Interface
- WIDTH, 8, counter/duty/TOP width in bits
- CHANNELS, 4, number of PWM outputs (1..16)
- ADDR_W (derived localparam), $clog2(CHANNELS+2), register address width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  register write strobe, one write per cycle
- wr_addr  in  ADDR_W  selects the register:
  - 0..CHANNELS-1: duty[i]
  - CHANNELS: TOP
  - CHANNELS+1: CTRL (bit0 EN, bit1 CENTER)
- wr_data  in  WIDTH  write data; CTRL uses bits [1:0] only
- pwm_out  out  CHANNELS  registered PWM outputs
- cnt_out  out  WIDTH  current period counter
- period_tick  out  1  high for the first cycle of each period

## Operation
- Register banks:
  - Shadow registers: duty[i], TOP, CENTER. Written immediately on wr_en.
  - Active copies are loaded from the shadows at every period boundary, and every cycle while EN=0.
  - EN is not shadowed; it acts immediately.
- Boundary write: a write landing in a boundary cycle is forwarded, so the active register takes wr_data.
- Invalid addresses (≥CHANNELS+2) are ignored.
- Edge mode (CENTER=0):
  - cnt runs 0,1..TOP and then wraps to 0. Period = TOP+1.
  - Boundary = cycle with cnt==TOP (the next cnt is 0).
- Center mode (CENTER=1): states UP and DOWN.
  - UP: cnt 0..TOP-1, then enter DOWN holding cnt at TOP-1 for one more cycle.
  - DOWN: cnt TOP-1..0, then enter UP holding cnt at 0 for one more cycle.
  - Period = 2·TOP. Boundary = last DOWN cycle (cnt==0).
- TOP=0 in either mode: cnt holds 0, every cycle is a boundary, period = 1.
- Compare: pwm_out[i] <= EN && (cnt < duty_active[i]).
  - duty=0 gives constant low.
  - duty ≥ period span gives constant high.
  - Edge high-time = min(duty, TOP+1). Center high-time = 2·min(duty, TOP).
- period_tick = EN && cnt==0 && (UP or edge mode). It is a function of registered state only.
- EN 1→0: next cycle cnt=0, state UP, pwm_out=0, period_tick=0. Shadows then flow into the active registers each cycle.
- EN 0→1: cnt starts at 0 in the cycle after the write. The first period uses the current shadow values.
- Arithmetic is unsigned, WIDTH bits. cnt never exceeds TOP, so there is no overflow path.

## Timing
- Reset values:
  - cnt_out=0, state UP, pwm_out=0, period_tick=0.
  - All duty shadow/active = 0.
  - TOP shadow/active = 2^WIDTH-1.
  - EN=0, CENTER=0.
- Reset mid-operation: the above values appear in the cycle after rst is sampled high. rst overrides a simultaneous wr_en.
- Latency:
  - pwm_out lags cnt_out by exactly 1 cycle.
  - A duty/TOP/CENTER write while running affects the first cycle of the next period.
  - A write while disabled is visible in the active registers the next cycle.
- Simultaneous wr_en to CTRL with EN=0 during a boundary: disable wins, and CENTER is still captured into the shadow.

## Structure
- Package pwm_pkg holds:
  - CTRL bit indices (CTRL_EN=0, CTRL_CENTER=1).
  - The state enum (ST_UP, ST_DOWN).
  - Functions for the register offsets: top_addr(CHANNELS), ctrl_addr(CHANNELS).
- Sub-module pwm_channel, one instance per channel. It contains the duty shadow/active pair, the forward-on-boundary logic, the compare and the pwm_out flop.
- The top level holds the counter FSM, TOP/CTRL registers and address decode.

## Test plan
- Edge mode, TOP=9, duty0=3, EN=1 → pwm_out[0] high 3 of every 10 cycles; period_tick every 10 cycles; cnt_out 0..9.
- Edge mode, TOP=9, duty1=0, duty2=10, duty3=255 → pwm_out[1] constant 0; pwm_out[2] and pwm_out[3] constant 1 after the first cycle.
- Running, TOP=9, duty0=3; write duty0=7 at cnt=4 → current period stays 3-high; the next period is 7-high. A repeat with the write in the cnt==9 cycle → 7-high from the very next period.
- Center mode, TOP=4, duty0=2 → cnt 0,1,2,3,3,2,1,0 repeating; pwm_out[0] (one cycle late) H,H,L,L,L,L,H,H; period_tick every 8 cycles.
- EN cleared at cnt=5 → next cycle cnt_out=0 and pwm_out=0. A duty write while disabled, then EN=1 → the new duty is used in the first period.
- Assert rst mid-period with wr_en active → all outputs at reset values next cycle; the write is discarded; TOP reads back behaviour as 255 (period 256).
